// File: rtl/soc1_pio_pkg.sv
// soc1_pio_pkg: shared constants for the soc1 parallel-I/O slaves.
// Holds the word-address map of the input PIO, the EDGE_TYPE encodings
// and a helper sizing the debounce counter.
package soc1_pio_pkg;

  // Word addresses decoded by the input PIO.
  typedef enum logic [2:0] {
    ADDR_DATA    = 3'd0,
    ADDR_IRQMASK = 3'd2,
    ADDR_EDGECAP = 3'd3
  } pio_addr_e;

  // Edge selection for the capture register.
  localparam int EDGE_RISE = 0;
  localparam int EDGE_FALL = 1;
  localparam int EDGE_ANY  = 2;

  // Counter width for a debounce window of 'cycles'; never narrower than 1 bit.
  function automatic int cnt_width(input int cycles);
    return (cycles < 1) ? 1 : $clog2(cycles + 1);
  endfunction

endpackage

// File: rtl/soc1_pio_debounce.sv
// soc1_pio_debounce: one-bit two-flop synchronizer followed by a debounce filter.
// Latency: 2 + DEBOUNCE_CYCLES clk cycles from din to dout.
// Backpressure: none; free-running sampler.
// Ports: clk, reset (async, active-high), din (asynchronous input), dout (debounced level).
module soc1_pio_debounce
  import soc1_pio_pkg::*;
#(
  parameter int   DEBOUNCE_CYCLES = 16,
  parameter logic IDLE_LEVEL      = 1'b1
) (
  input  logic clk,
  input  logic reset,
  input  logic din,
  output logic dout
);

  localparam int CW = cnt_width(DEBOUNCE_CYCLES);

  logic sync0;
  logic sync1;
  logic stable;

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      sync0 <= IDLE_LEVEL;
      sync1 <= IDLE_LEVEL;
    end else begin
      sync0 <= din;
      sync1 <= sync0;
    end
  end

  generate
    if (DEBOUNCE_CYCLES == 0) begin : g_bypass
      always_ff @(posedge clk or posedge reset) begin
        if (reset) stable <= IDLE_LEVEL;
        else       stable <= sync1;
      end
    end else begin : g_count
      localparam logic [CW-1:0] LAST = CW'(DEBOUNCE_CYCLES - 1);
      logic [CW-1:0] cnt;

      // cnt counts consecutive cycles in which sync1 disagrees with stable;
      // any agreeing cycle restarts it, so short glitches never get through.
      always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
          stable <= IDLE_LEVEL;
          cnt    <= '0;
        end else if (sync1 == stable) begin
          cnt <= '0;
        end else if (cnt == LAST) begin
          stable <= sync1;
          cnt    <= '0;
        end else begin
          cnt <= cnt + CW'(1);
        end
      end
    end
  endgenerate

  assign dout = stable;

endmodule

// File: rtl/soc1_pio_in_edge.sv
// soc1_pio_in_edge: Avalon-MM input PIO with debounce, sticky edge capture and maskable irq.
// Latency: in_port to data 2+DEBOUNCE_CYCLES cycles, to edge_capture +1, to irq +2; reads zero-latency.
// Backpressure: none; slave always ready, reads are combinational and side-effect free.
// Ports: clk, reset (async, active-high); address/chipselect/write_n/writedata/readdata slave bus;
//        in_port (asynchronous inputs); irq (registered level interrupt).
module soc1_pio_in_edge
  import soc1_pio_pkg::*;
#(
  parameter int   WIDTH           = 4,
  parameter int   EDGE_TYPE       = EDGE_FALL,
  parameter int   DEBOUNCE_CYCLES = 16,
  parameter logic IDLE_LEVEL      = 1'b1
) (
  input  logic             clk,
  input  logic             reset,
  input  logic [2:0]       address,
  input  logic             chipselect,
  input  logic             write_n,
  input  logic [31:0]      writedata,
  output logic [31:0]      readdata,
  input  logic [WIDTH-1:0] in_port,
  output logic             irq
);

  logic [WIDTH-1:0] stable;
  logic [WIDTH-1:0] prev;
  logic [WIDTH-1:0] rise;
  logic [WIDTH-1:0] fall;
  logic [WIDTH-1:0] edge_event;
  logic [WIDTH-1:0] edge_capture;
  logic [WIDTH-1:0] irq_mask;
  logic [WIDTH-1:0] clr;
  logic             wr;
  logic             unused_wdata;

  genvar gi;
  generate
    for (gi = 0; gi < WIDTH; gi++) begin : g_bit
      soc1_pio_debounce #(
        .DEBOUNCE_CYCLES(DEBOUNCE_CYCLES),
        .IDLE_LEVEL     (IDLE_LEVEL)
      ) u_debounce (
        .clk  (clk),
        .reset(reset),
        .din  (in_port[gi]),
        .dout (stable[gi])
      );
    end
  endgenerate

  // prev resets to 0 while stable resets to IDLE_LEVEL, so with active-low
  // keys the first post-reset cycle looks like a rising edge; falling-edge
  // capture (the default) is unaffected.
  always_ff @(posedge clk or posedge reset) begin
    if (reset) prev <= '0;
    else       prev <= stable;
  end

  assign rise = stable & ~prev;
  assign fall = ~stable & prev;

  always_comb begin
    edge_event = fall;
    if (EDGE_TYPE == EDGE_RISE)     edge_event = rise;
    else if (EDGE_TYPE == EDGE_ANY) edge_event = rise | fall;
  end

  assign wr  = chipselect & ~write_n;
  assign clr = (wr && (address == ADDR_EDGECAP)) ? writedata[WIDTH-1:0] : '0;

  // A new edge is ORed in after the clear, so a coincident set wins.
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      irq_mask     <= '0;
      edge_capture <= '0;
      irq          <= 1'b0;
    end else begin
      if (wr && (address == ADDR_IRQMASK)) irq_mask <= writedata[WIDTH-1:0];
      edge_capture <= (edge_capture & ~clr) | edge_event;
      irq          <= |(edge_capture & irq_mask);
    end
  end

  // Decode ignores chipselect: unmapped addresses always read 0.
  always_comb begin
    readdata = '0;
    case (address)
      ADDR_DATA:    readdata[WIDTH-1:0] = stable;
      ADDR_IRQMASK: readdata[WIDTH-1:0] = irq_mask;
      ADDR_EDGECAP: readdata[WIDTH-1:0] = edge_capture;
      default:      readdata = '0;
    endcase
  end

  // Bits of writedata above WIDTH carry no state.
  assign unused_wdata = ^writedata;

endmodule
